// File: rtl/fdc_disk_sequencer.sv
// fdc_disk_sequencer
// Moves one FDC disk request at a time through the host MCU mailbox.
// Flow per request: latch the request, post a 32-bit command word with a
// 4-phase handshake, stream sector bytes (host->FDC FIFO for reads,
// FDC FIFO->host for writes), then emit a one-cycle completion pulse.
// A watchdog aborts any host wait that runs too long.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_*                       FDC request (valid/ready, op, drive, head, track, sector)
//   host_cmd, host_cmd_valid    mailbox command word and request level
//   host_ack                    mailbox acknowledge level
//   host_done/err/id            host completion pulse with status and sector ID
//   host_rx_valid/data          read bytes from host
//   host_tx_valid/ready/data    write bytes to host
//   fifo_wr/wdata               push into FDC read FIFO
//   fifo_rd/rdata               pop from FDC write FIFO (data one cycle after fifo_rd)
//   done, done_*                completion pulse and its fields
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | ready for a request
// ISSUE       | command word posted, waiting for host_ack high
// WAIT_ACKLOW | command withdrawn, waiting for host_ack low
// XFER_IN     | read: host bytes pushed into the FDC FIFO
// XFER_OUT    | write: FDC FIFO bytes handed to the host
// WAIT_DONE   | waiting for the host completion pulse
// COMPLETE    | one-cycle done pulse, then back to IDLE

module fdc_disk_sequencer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_drive,
    input  logic        req_head,
    input  logic [6:0]  req_track,
    input  logic [7:0]  req_sector,
    output logic [31:0] host_cmd,
    output logic        host_cmd_valid,
    input  logic        host_ack,
    input  logic        host_done,
    input  logic        host_err,
    input  logic [7:0]  host_id,
    input  logic        host_rx_valid,
    input  logic [7:0]  host_rx_data,
    input  logic        host_tx_ready,
    output logic        host_tx_valid,
    output logic        fifo_wr,
    output logic [7:0]  fifo_wdata,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_rdata,
    output logic [7:0]  host_tx_data,
    output logic        done,
    output logic        done_err,
    output logic        done_timeout,
    output logic [1:0]  done_op,
    output logic        done_drive,
    output logic [7:0]  done_id
);

    localparam int CW = $clog2(SECTOR_BYTES) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(SECTOR_BYTES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACKLOW, S_XFER_IN, S_XFER_OUT, S_WAIT_DONE, S_COMPLETE
    } state_t;

    // Write byte phases: pop the FIFO, present the popped byte straight
    // from fifo_rdata, then hold it from a local copy until the host takes it.
    typedef enum logic [1:0] {PH_RD, PH_FIRST, PH_HOLD} out_ph_t;

    state_t        state_q, state_d;
    out_ph_t       out_ph_q;
    logic [1:0]    op_q;
    logic          drive_q, head_q;
    logic [6:0]    track_q;
    logic [7:0]    sector_q;
    logic [CW-1:0] cnt_q, cnt_after;
    logic [23:0]   wd_q;
    logic          err_q, to_q;
    logic [7:0]    id_q, tx_q;
    logic          byte_evt, wd_expired, cap_done, cap_to, in_xfer;

    assign wd_expired = (wd_q == 24'd0);
    assign in_xfer    = (state_q == S_XFER_IN) || (state_q == S_XFER_OUT);
    // A byte moving in the same cycle as host_done is counted before the
    // short-transfer check.
    assign cnt_after  = byte_evt ? (cnt_q + CNT_ONE) : cnt_q;

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        host_cmd_valid = 1'b0;
        fifo_wr        = 1'b0;
        fifo_rd        = 1'b0;
        host_tx_valid  = 1'b0;
        byte_evt       = 1'b0;
        cap_done       = 1'b0;
        cap_to         = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                host_cmd_valid = 1'b1;
                if (host_ack) begin
                    state_d = S_WAIT_ACKLOW;
                end else if (wd_expired) begin
                    state_d = S_COMPLETE;
                    cap_to  = 1'b1;
                end
            end
            S_WAIT_ACKLOW: begin
                if (!host_ack) begin
                    case (op_q)
                        2'd1:    state_d = S_XFER_IN;
                        2'd2:    state_d = S_XFER_OUT;
                        default: state_d = S_WAIT_DONE;
                    endcase
                end else if (wd_expired) begin
                    state_d = S_COMPLETE;
                    cap_to  = 1'b1;
                end
            end
            S_XFER_IN: begin
                fifo_wr  = host_rx_valid;
                byte_evt = host_rx_valid;
            end
            S_XFER_OUT: begin
                fifo_rd       = (out_ph_q == PH_RD);
                host_tx_valid = (out_ph_q != PH_RD);
                byte_evt      = (out_ph_q != PH_RD) && host_tx_ready;
            end
            S_WAIT_DONE: begin
                if (host_done) begin
                    state_d  = S_COMPLETE;
                    cap_done = 1'b1;
                end else if (wd_expired) begin
                    state_d = S_COMPLETE;
                    cap_to  = 1'b1;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (in_xfer) begin
            if (host_done) begin
                state_d  = S_COMPLETE;
                cap_done = 1'b1;
            end else if (byte_evt && (cnt_after == CNT_FULL)) begin
                state_d = S_WAIT_DONE;
            end else if (!byte_evt && wd_expired) begin
                state_d = S_COMPLETE;
                cap_to  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            out_ph_q <= PH_RD;
            op_q     <= 2'd0;
            drive_q  <= 1'b0;
            head_q   <= 1'b0;
            track_q  <= 7'd0;
            sector_q <= 8'd0;
            cnt_q    <= '0;
            wd_q     <= 24'd0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            id_q     <= 8'd0;
            tx_q     <= 8'd0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && req_valid) begin
                op_q     <= req_op;
                drive_q  <= req_drive;
                head_q   <= req_head;
                track_q  <= req_track;
                sector_q <= req_sector;
            end

            if (state_q == S_COMPLETE) cnt_q <= '0;
            else if (byte_evt)         cnt_q <= cnt_after;

            // Down-counting watchdog, reloaded on any progress.
            if (state_d != state_q || byte_evt)
                wd_q <= TIMEOUT_CYCLES - 24'd1;
            else if (state_q != S_IDLE && state_q != S_COMPLETE && !wd_expired)
                wd_q <= wd_q - 24'd1;

            if (state_q != S_XFER_OUT) begin
                out_ph_q <= PH_RD;
            end else begin
                case (out_ph_q)
                    PH_RD:    out_ph_q <= PH_FIRST;
                    PH_FIRST: begin
                        tx_q     <= fifo_rdata;
                        out_ph_q <= byte_evt ? PH_RD : PH_HOLD;
                    end
                    PH_HOLD:  if (byte_evt) out_ph_q <= PH_RD;
                    default:  out_ph_q <= PH_RD;
                endcase
            end

            if (cap_done) begin
                err_q <= host_err | (in_xfer && (cnt_after != CNT_FULL));
                to_q  <= 1'b0;
                id_q  <= host_id;
            end else if (cap_to) begin
                err_q <= 1'b1;
                to_q  <= 1'b1;
                id_q  <= 8'd0;
            end
        end
    end

    assign host_cmd     = {6'b0, op_q, 7'b0, drive_q, head_q, track_q, sector_q};
    assign fifo_wdata   = fifo_wr ? host_rx_data : 8'd0;
    assign host_tx_data = !host_tx_valid ? 8'd0 :
                          (out_ph_q == PH_FIRST) ? fifo_rdata : tx_q;
    assign done         = (state_q == S_COMPLETE);
    assign done_err     = done & err_q;
    assign done_timeout = done & to_q;
    assign done_op      = done ? op_q : 2'd0;
    assign done_drive   = done & drive_q;
    assign done_id      = done ? id_q : 8'd0;

endmodule

// File: doc/fdc_disk_sequencer.md
Name: fdc_disk_sequencer

Overview:
- Sequences disk-image transactions between the NEC765-style FDC core and the host MCU that owns the disk images.
- Accepts one request at a time from the FDC: seek, read sector, write sector or read ID.
- Issues the request as a 32-bit command word over a 4-phase mailbox handshake, then streams the sector bytes between host and FDC FIFOs.
- Returns a single completion pulse carrying the status, and enforces a watchdog timeout.

Parameters:
- SECTOR_BYTES, 512, bytes moved per read/write transfer.
- TIMEOUT_CYCLES, 24'd12000000, max cycles spent in any host-wait state before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  FDC request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=seek 1=read 2=write 3=readid
- req_drive  in  1  unit select
- req_head  in  1  head
- req_track  in  7  cylinder
- req_sector  in  8  sector ID
- host_cmd  out  32  {6'b0, op[1:0], 7'b0, drive, head, track[6:0], sector[7:0]}
- host_cmd_valid  out  1  mailbox request level
- host_ack  in  1  mailbox acknowledge level
- host_done  in  1  host completion pulse
- host_err  in  1  host error, sampled with host_done
- host_id  in  8  sector ID reported by host, sampled with host_done
- host_rx_valid  in  1  host byte strobe (read data)
- host_rx_data  in  8  read data byte
- host_tx_ready  in  1  host takes a write byte
- host_tx_valid  out  1  write byte presented
- fifo_wr  out  1  push strobe into FDC read FIFO
- fifo_wdata  out  8  byte pushed
- fifo_rd  out  1  pop strobe from FDC write FIFO
- fifo_rdata  in  8  popped byte, valid the cycle after fifo_rd; forwarded to the host as host_tx_data
- host_tx_data  out  8  write byte
- done  out  1  one-cycle completion pulse
- done_err  out  1  completion error
- done_timeout  out  1  completion caused by watchdog
- done_op  out  2  op that completed
- done_drive  out  1  drive that completed
- done_id  out  8  host_id captured at completion; 0 on timeout

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE, byte counter=0, timer=0.
- Reset asserted in any state returns to IDLE within one cycle. The pending request is dropped and no done pulse is generated.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/drive/head/track/sector and go to ISSUE.
  - req_ready drops the next cycle.
- ISSUE:
  - host_cmd_valid=1 and host_cmd stable.
  - When host_ack=1, deassert host_cmd_valid and go to WAIT_ACKLOW.
- WAIT_ACKLOW: when host_ack=0, go to XFER_IN (read), XFER_OUT (write) or WAIT_DONE (seek/readid).
- XFER_IN:
  - Each host_rx_valid produces fifo_wr=1 with fifo_wdata=host_rx_data in the same cycle, and increments the counter.
  - When the counter reaches SECTOR_BYTES, go to WAIT_DONE.
- XFER_OUT:
  - Pulse fifo_rd, then present the byte with host_tx_valid=1 until host_tx_ready=1.
  - Repeat until SECTOR_BYTES bytes are accepted, then go to WAIT_DONE.
  - Max one byte per 2 cycles.
- WAIT_DONE: on host_done, capture host_err and host_id, go to COMPLETE.
- COMPLETE:
  - done=1 for one cycle with captured fields.
  - Counter clears and state returns to IDLE; req_ready=1 the next cycle.
- host_done arriving during XFER_IN/XFER_OUT:
  - Terminates the transfer immediately.
  - done_err = host_err OR (count != SECTOR_BYTES).
  - If host_done coincides with the final rx byte, that byte is pushed and counted first, so there is no error unless host_err=1.
- host_rx_valid outside XFER_IN is ignored: no fifo_wr.
- Watchdog:
  - Counts in ISSUE, WAIT_ACKLOW, XFER_*, and WAIT_DONE.
  - Clears on every state change and on each transferred byte.
  - On reaching TIMEOUT_CYCLES, go to COMPLETE with done_err=1, done_timeout=1, done_id=0. host_cmd_valid is dropped.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.
- Counter width is clog2(SECTOR_BYTES)+1. It never wraps, because the transfer ends at SECTOR_BYTES.

Test Plan:
1. Seek, drive 1, track 39:
   - req_op=0, req_track=39 → host_cmd=32'h0001_2700|sector.
   - host_ack high then low, host_done with err=0 → done=1, done_op=0, done_drive=1, done_err=0.
2. Read, 512 bytes:
   - Host streams bytes 0..255,0..255 → exactly 512 fifo_wr pulses with matching data.
   - host_done with host_id=8'hC3 → done_id=8'hC3, done_err=0.
3. Write:
   - fifo_rdata returns incrementing bytes → 512 host_tx handshakes in order, with host_tx_ready toggling randomly.
   - done_op=2.
4. Short read: host_done after 100 bytes → fifo_wr count=100, done_err=1, next request accepted.
5. Timeout: TIMEOUT_CYCLES=1000 and host never acks → done at cycle ≈1002 after ISSUE, done_timeout=1, host_cmd_valid=0.
6. Reset asserted mid-XFER_IN after 10 bytes → no done pulse, req_ready=1 after reset, next read completes normally with 512 bytes.
